vector_memory_reader: RTL

Read-out engine for the vector data memory. It fetches a run of consecutive DATA_WIDTH*VECTOR_SIZE-bit words written by the CPU pipeline and unpacks each word into VECTOR_SIZE scalar elements. The elements are streamed element 0 first over a valid/ready handshake to a host or debug sink. It sits on the memory's second read port, beside the CPU's Memory stage, and is the consumer of the data the CPU's store path writes.

---
 rtl/vector_reader_pkg.sv | 23 ++
 rtl/vector_unpacker.sv | 47 ++++
 rtl/vector_memory_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/vector_reader_pkg.sv
// vector_reader_pkg
// Shared types and helpers for the vector memory read-out engine.
//   state_t       : read-out FSM states
//   READ_LATENCY  : cycles from readEnable to valid readData
//   idx_width()   : width of the element index counter
package vector_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        STREAM,
        DONE
    } state_t;

    localparam int READ_LATENCY = 1;

    // Keeps the counter at least one bit wide when a word holds one element.
    function automatic int idx_width(input int vector_size);
        return (vector_size > 1) ? $clog2(vector_size) : 1;
    endfunction

endpackage

// File: rtl/vector_unpacker.sv
// vector_unpacker
// Holds one memory word and presents it one element at a time, element 0
// (least-significant slice) first.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture wordIn, restart at element 0
//   advance      : step to the next element (ignored on the last one)
//   wordIn       : DATA_WIDTH*VECTOR_SIZE memory word
//   elementData  : currently selected element
//   lastElement  : index points at the final element of the word
module vector_unpacker
    import vector_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int VECTOR_SIZE = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              load,
    input  logic                              advance,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] wordIn,
    output logic [DATA_WIDTH-1:0]             elementData,
    output logic                              lastElement
);

    localparam int IDX_W = idx_width(VECTOR_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

    logic [DATA_WIDTH*VECTOR_SIZE-1:0] buffer_q;
    logic [IDX_W-1:0]                  idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer_q <= '0;
            idx_q    <= '0;
        end else if (load) begin
            buffer_q <= wordIn;
            idx_q    <= '0;
        end else if (advance && !lastElement) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign lastElement = (idx_q == LAST_IDX);
    assign elementData = buffer_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/vector_memory_reader.sv
// vector_memory_reader
// Fetches wordCount consecutive words from the vector data memory and streams
// their elements over a valid/ready handshake.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   start, abort          : begin a transfer (IDLE only) / cancel a running one
//   startAddress,wordCount: transfer description, latched on accepted start
//   readEnable,readAddress: memory read port (data returns one cycle later)
//   readData              : memory word
//   elementValid/Ready    : element stream handshake
//   elementData,elementLast: current element, final element of the transfer
//   busy, done            : not IDLE / one-cycle completion pulse
module vector_memory_reader
    import vector_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDRESS_WIDTH-1:0]          startAddress,
    input  logic [ADDRESS_WIDTH:0]            wordCount,
    output logic                              readEnable,
    output logic [ADDRESS_WIDTH-1:0]          readAddress,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] readData,
    output logic                              elementValid,
    input  logic                              elementReady,
    output logic [DATA_WIDTH-1:0]             elementData,
    output logic                              elementLast,
    output logic                              busy,
    output logic                              done
);

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] addr_d;
    logic [ADDRESS_WIDTH:0]   remaining_q;
    logic [ADDRESS_WIDTH-1:0] readAddress_q;

    logic                  handshake;
    logic                  unpackLast;
    logic [DATA_WIDTH-1:0] unpackData;

    assign handshake = (state_q == STREAM) && elementReady;
    // Natural overflow of the address width gives the 0xFF -> 0x00 wrap.
    assign addr_d    = addr_q + 1'b1;

    vector_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .VECTOR_SIZE(VECTOR_SIZE)
    ) u_unpacker (
        .clock      (clock),
        .reset      (reset),
        .load       (state_q == WAIT),
        .advance    (handshake),
        .wordIn     (readData),
        .elementData(unpackData),
        .lastElement(unpackLast)
    );

    // readAddress_q is loaded on entry to FETCH so the address is already on
    // the port during the strobe cycle; it then holds until the next fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            readAddress_q <= '0;
        end else if (abort && (state_q != IDLE)) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q        <= startAddress;
                        remaining_q   <= wordCount;
                        readAddress_q <= startAddress;
                        state_q       <= (wordCount == '0) ? DONE : FETCH;
                    end
                end
                FETCH:  state_q <= WAIT;
                WAIT:   state_q <= STREAM;
                STREAM: begin
                    if (handshake && unpackLast) begin
                        if (remaining_q == (ADDRESS_WIDTH+1)'(1)) begin
                            state_q <= DONE;
                        end else begin
                            remaining_q   <= remaining_q - 1'b1;
                            addr_q        <= addr_d;
                            readAddress_q <= addr_d;
                            state_q       <= FETCH;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; elementReady never reaches them.
    assign readEnable   = (state_q == FETCH);
    assign readAddress  = readAddress_q;
    assign elementValid = (state_q == STREAM);
    assign elementData  = elementValid ? unpackData : '0;
    assign elementLast  = elementValid && unpackLast
                          && (remaining_q == (ADDRESS_WIDTH+1)'(1));
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule
